// File: rtl/sdram_init_monitor.sv
// sdram_init_monitor: watches SDRAM command pins and checks the JEDEC power-up
// sequence PRE-all -> N x AUTO_REFRESH -> LOAD_MODE_REGISTER, with minimum NOP gaps.
// Latency: every output reflects the command sampled on the preceding sys_clk edge.
// Backpressure: none; this is a passive observer and accepts one command per cycle.
//
// Ports:
//   sys_clk    - 100 MHz clock
//   sys_rst    - synchronous active-high reset
//   cmd        - {cs#,ras#,cas#,we#} as seen on the pins
//   ba         - bank address (not used for decoding)
//   addr       - A12..A0
//   init_done  - legal init sequence completed (terminal until reset)
//   err        - sticky protocol violation
//   err_code   - first violation: 1 early PRE, 2 wrong command, 3 tRP, 4 tRFC,
//                5 tMRD, 6 PRE without A10, 7 unsupported CAS latency
//   ar_cnt     - AUTO_REFRESH commands accepted, saturating at 3
//   cas_lat    - latched A6..A4 of the accepted LMR
//   burst_type - latched A3
//   burst_len  - latched A2..A0
//   wr_single  - latched A9
module sdram_init_monitor #(
  parameter int WAIT_CLK = 10000,
  parameter int TRP_CLK  = 2,
  parameter int TRFC_CLK = 7,
  parameter int TMRD_CLK = 2,
  parameter int A_R_TIME = 2
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic [3:0]  cmd,
  input  logic [1:0]  ba,
  input  logic [12:0] addr,
  output logic        init_done,
  output logic        err,
  output logic [2:0]  err_code,
  output logic [1:0]  ar_cnt,
  output logic [2:0]  cas_lat,
  output logic        burst_type,
  output logic [2:0]  burst_len,
  output logic        wr_single
);

  typedef enum logic [2:0] {
    M_PWR,
    M_TRP,
    M_TRFC,
    M_TMRD,
    M_DONE,
    M_ERR
  } mstate_t;

  localparam logic [3:0] CMD_NOP = 4'b0111;
  localparam logic [3:0] CMD_PRE = 4'b0010;
  localparam logic [3:0] CMD_AR  = 4'b0001;
  localparam logic [3:0] CMD_LMR = 4'b0000;

  // Thresholds widened to 16 bits so the 15-bit gap (+1) compares without overflow.
  localparam logic [15:0] WAIT_W = 16'(WAIT_CLK);
  localparam logic [15:0] TRP_W  = 16'(TRP_CLK);
  localparam logic [15:0] TRFC_W = 16'(TRFC_CLK);
  localparam logic [15:0] TMRD_W = 16'(TMRD_CLK);
  localparam logic [2:0]  ART_W  = 3'(A_R_TIME);

  mstate_t     state;
  mstate_t     state_nxt;
  logic [14:0] gap;
  logic [15:0] gap_w;
  logic [15:0] gap_inc_w;
  logic        is_nop;
  logic        is_pre;
  logic        is_ar;
  logic        is_lmr;
  logic        fault;
  logic [2:0]  fault_code;
  logic [1:0]  ar_nxt;
  logic        mode_ld;
  logic        cas_ok;
  logic        unused_bits;

  // Bank address and the mode-register bits we do not interpret are ignored.
  assign unused_bits = ^{ba, addr[12:11], addr[8:7]};

  // Chip-select deasserted means the device sees a NOP whatever the other pins say.
  assign is_nop    = cmd[3] | (cmd == CMD_NOP);
  assign is_pre    = (cmd == CMD_PRE);
  assign is_ar     = (cmd == CMD_AR);
  assign is_lmr    = (cmd == CMD_LMR);
  assign gap_w     = {1'b0, gap};
  assign gap_inc_w = gap_w + 16'd1;
  assign cas_ok    = (addr[6:4] == 3'b010) || (addr[6:4] == 3'b011);

  always_comb begin
    state_nxt  = state;
    fault      = 1'b0;
    fault_code = 3'd0;
    ar_nxt     = ar_cnt;
    mode_ld    = 1'b0;
    case (state)
      M_PWR: begin
        if (!is_nop) begin
          if (is_pre) begin
            if (gap_w < WAIT_W) begin
              fault      = 1'b1;
              fault_code = 3'd1;
            end else if (!addr[10]) begin
              fault      = 1'b1;
              fault_code = 3'd6;
            end else begin
              state_nxt = M_TRP;
            end
          end else begin
            fault      = 1'b1;
            fault_code = 3'd2;
          end
        end
      end
      M_TRP: begin
        if (!is_nop) begin
          if (!is_ar) begin
            fault      = 1'b1;
            fault_code = 3'd2;
          end else if (gap_w < TRP_W) begin
            fault      = 1'b1;
            fault_code = 3'd3;
          end else begin
            state_nxt = M_TRFC;
            ar_nxt    = 2'd1;
          end
        end
      end
      M_TRFC: begin
        if (!is_nop) begin
          if (gap_w < TRFC_W) begin
            fault      = 1'b1;
            fault_code = 3'd4;
          end else if (is_ar) begin
            ar_nxt = (ar_cnt == 2'd3) ? ar_cnt : ar_cnt + 2'd1;
          end else if (is_lmr && ({1'b0, ar_cnt} >= ART_W)) begin
            if (cas_ok) begin
              state_nxt = M_TMRD;
              mode_ld   = 1'b1;
            end else begin
              fault      = 1'b1;
              fault_code = 3'd7;
            end
          end else begin
            fault      = 1'b1;
            fault_code = 3'd2;
          end
        end
      end
      M_TMRD: begin
        if (!is_nop) begin
          fault      = 1'b1;
          fault_code = 3'd5;
        end else if (gap_inc_w >= TMRD_W) begin
          // This NOP completes the tMRD window.
          state_nxt = M_DONE;
        end
      end
      default: begin
        // M_DONE and M_ERR are terminal until reset.
        state_nxt = state;
      end
    endcase
    if (fault) begin
      state_nxt = M_ERR;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state      <= M_PWR;
      gap        <= 15'd0;
      init_done  <= 1'b0;
      err        <= 1'b0;
      err_code   <= 3'd0;
      ar_cnt     <= 2'd0;
      cas_lat    <= 3'd0;
      burst_type <= 1'b0;
      burst_len  <= 3'd0;
      wr_single  <= 1'b0;
    end else begin
      state     <= state_nxt;
      init_done <= (state_nxt == M_DONE);
      ar_cnt    <= ar_nxt;
      if (!is_nop) begin
        gap <= 15'd0;
      end else if (gap != 15'h7fff) begin
        gap <= gap + 15'd1;
      end
      // fault is only raised outside the terminal states, so the first code sticks.
      if (fault) begin
        err      <= 1'b1;
        err_code <= fault_code;
      end
      if (mode_ld) begin
        cas_lat    <= addr[6:4];
        burst_type <= addr[3];
        burst_len  <= addr[2:0];
        wr_single  <= addr[9];
      end
    end
  end

endmodule

// File: doc/sdram_init_monitor.md
SDRAM_INIT_MONITOR -- requirements
Module: sdram_init_monitor

Interface
REQ-001 The block SHALL run on one clock, sys_clk; the reset, sys_rst, SHALL be synchronous and active-high, sampled on the sys_clk rising edge.
REQ-002 Parameters, one per line (name, default, meaning):
- WAIT_CLK, 10000, minimum power-up NOP cycles before PRECHARGE.
- TRP_CLK, 2, minimum NOP cycles between PRECHARGE and AUTO_REFRESH.
- TRFC_CLK, 7, minimum NOP cycles after each AUTO_REFRESH.
- TMRD_CLK, 2, minimum NOP cycles after LOAD_MODE_REGISTER.
- A_R_TIME, 2, required AUTO_REFRESH count.
REQ-003 Ports, one per line (name, direction, width, meaning):
- sys_clk input 1 -- clock, 100 MHz.
- sys_rst input 1 -- synchronous active-high reset.
- cmd input 4 -- {cs#,ras#,cas#,we#} observed on the SDRAM pins.
- ba input 2 -- bank address.
- addr input 13 -- A12-A0.
- init_done output 1 -- legal init sequence completed.
- err output 1 -- sticky protocol violation.
- err_code output 3 -- first violation code.
- ar_cnt output 2 -- AUTO_REFRESH commands accepted, saturating at 3.
- cas_lat output 3 -- latched A6-A4.
- burst_type output 1 -- latched A3.
- burst_len output 3 -- latched A2-A0.
- wr_single output 1 -- latched A9.

Function
REQ-004 The block SHALL decode NOP = 4'b0111, PRECHARGE = 4'b0010, AUTO_REFRESH = 4'b0001 and LMR = 4'b0000; any cmd with cs# = 1 SHALL be treated as NOP.
REQ-005 The block SHALL keep a 15-bit gap counter of consecutive NOP cycles, which saturates at 32767 and clears to 0 on every non-NOP command.
REQ-006 States SHALL be: M_PWR, M_TRP, M_TRFC, M_TMRD, M_DONE, M_ERR.
REQ-007 In M_PWR:
- PRECHARGE with gap >= WAIT_CLK and addr[10] = 1 -> M_TRP.
- PRECHARGE with gap < WAIT_CLK -> error code 1.
- PRECHARGE with addr[10] = 0 -> error code 6.
- Any other non-NOP command -> error code 2.
REQ-008 In M_TRP:
- AUTO_REFRESH with gap >= TRP_CLK -> M_TRFC, ar_cnt = 1.
- AUTO_REFRESH with gap < TRP_CLK -> error code 3.
- Any other non-NOP command -> error code 2.
REQ-009 Every command in M_TRFC that arrives with gap < TRFC_CLK SHALL raise error code 4. Once gap >= TRFC_CLK:
- AUTO_REFRESH increments ar_cnt and stays in M_TRFC.
- LMR with ar_cnt >= A_R_TIME -> M_TMRD.
- LMR with ar_cnt < A_R_TIME -> error code 2.
- PRECHARGE -> error code 2.
REQ-010 On the accepted LMR, the block SHALL latch cas_lat = addr[6:4], burst_type = addr[3], burst_len = addr[2:0] and wr_single = addr[9]. If addr[6:4] is not 3'b010 or 3'b011, it SHALL raise error code 7 instead of entering M_TMRD.
REQ-011 In M_TMRD, any non-NOP command SHALL raise error code 5; once gap reaches TMRD_CLK, the state SHALL become M_DONE and init_done SHALL rise on the next cycle.
REQ-012 M_DONE SHALL be terminal: later commands are ignored, init_done stays 1 and the mode fields hold.
REQ-013 On any error the state SHALL become M_ERR, err = 1 and err_code is set, all one cycle after the offending command is sampled. M_ERR SHALL be terminal: only the first code is kept and init_done stays 0.
REQ-014 All outputs SHALL be registered, and each output SHALL reflect the command sampled on the preceding edge.
REQ-015 The ba input SHALL be ignored for decoding.

Reset
REQ-016 While sys_rst = 1, the block SHALL set: state = M_PWR, gap = 0, init_done = 0, err = 0, err_code = 0, ar_cnt = 0, cas_lat = 0, burst_type = 0, burst_len = 0, wr_single = 0.
REQ-017 Reset asserted in any state, including M_DONE or M_ERR, SHALL restart monitoring from M_PWR on the first edge with sys_rst = 0. NOP cycles seen during reset SHALL NOT count toward the gap.

Verification
REQ-018 Nominal sequence: 10000 NOP, PRE with addr = 13'h1fff, 2 NOP, AR, 7 NOP, AR, 7 NOP, LMR with addr = 13'h0037, 2 NOP -> init_done = 1, ar_cnt = 2, cas_lat = 3, burst_len = 7, burst_type = 0, wr_single = 0, err = 0.
REQ-019 Early precharge: PRE after 9999 NOP -> err = 1, err_code = 1, init_done stays 0.
REQ-020 Refresh timing: second AR after only 6 NOP -> err_code = 4; separately, a sequence with 3 ARs, each 7 NOP apart -> ar_cnt = 3 and init_done = 1.
REQ-021 Bad mode and tMRD: LMR with addr[6:4] = 3'b001 -> err_code = 7; LMR legal, then AR after 1 NOP -> err_code = 5.
REQ-022 Reset recovery: sys_rst pulsed for 1 cycle from M_DONE -> all outputs 0, then a full nominal sequence passes again. A second violation after the first leaves err_code unchanged.
